ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Reads the decoded operands and instruction word that the ID/EX pipeline register holds.
- Runs a multi-cycle operation and holds the ID/EX register through a stall output until the result is ready.
- Returns the 32-bit result to the EX result mux with a one-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, number of iteration cycles (one bit per cycle); must equal XLEN.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- EX_Instr  input  32  instruction from ID/EX register; funct3 = bits[14:12].
- EX_RD1  input  32  rs1 operand from ID/EX register.
- EX_RD2  input  32  rs2 operand from ID/EX register.
- EX_MulDiv_Valid  input  1  high when EX_Instr is an M-extension op (opcode 0110011, funct7 0000001).
- EX_Flush  input  1  synchronous abort (branch mispredict/trap).
- MD_Stall  output  1  hold request to PC, IF/ID and ID/EX registers.
- MD_Busy  output  1  unit not in IDLE.
- MD_Done  output  1  one-cycle pulse; MD_Result valid.
- MD_Result  output  32  result; held until the next start.

Behaviour:
- Reset values (async, rst=1): state IDLE, MD_Busy=0, MD_Done=0, MD_Result=0, all internal accumulators 0.
- States and transitions:
  - IDLE -> CALC when EX_MulDiv_Valid=1 and EX_Flush=0. Operands and funct3 are latched, along with the absolute values and sign flags.
  - IDLE -> DONE directly (special case) for DIV/DIVU/REM/REMU with a divide-by-zero or signed overflow.
  - CALC: counter runs 0..ITER-1 -> DONE after the cycle in which counter = ITER-1.
  - DONE -> IDLE unconditionally. Start requests in DONE are ignored.
- Start: MD_Stall = (IDLE & EX_MulDiv_Valid & ~EX_Flush) | CALC. It is combinational, so the start cycle already stalls. MD_Stall is low in DONE, so ID/EX advances at the end of the DONE cycle.
- Latency:
  - Normal ops: MD_Done is high exactly ITER+1 = 33 cycles after the start cycle.
  - Special-case divides: MD_Done is high 1 cycle after the start cycle.
- MD_Done is registered; it is high only while in DONE. MD_Result updates on entry to DONE and holds afterwards.
- Multiply: shift-add on unsigned magnitudes into a 64-bit product; one multiplier bit per CALC cycle.
  - Sign fix (64-bit two's-complement negate) is applied on the CALC->DONE transition.
  - Negate when signs differ: MULH uses both operands signed; MULHSU uses rs1 signed, rs2 unsigned; MULHU and MUL use no sign fix for MUL's low word (low word is sign-independent).
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide: restoring division on magnitudes; one quotient bit per CALC cycle.
  - DIV/REM: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- Special cases (RISC-V semantics):
  - Divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Flush: EX_Flush=1 in any state -> IDLE next edge. No MD_Done is issued and MD_Result is unchanged. Flush in the same cycle as a start: the start is not accepted.
- Reset mid-operation: immediate return to IDLE; outputs go to their reset values.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU are computed combinationally with a 64-bit signed/unsigned multiply.
  - IDLE -> DONE directly, so multiplies have 1-cycle latency; MD_Stall is high only in the start cycle.
  - Divides are unchanged.
- Undefined: all ops iterate as described above; no hardware multiplier is inferred.

Test Plan:
- Reset mid-CALC: start DIVU 100/7, assert rst at cycle 10 -> MD_Busy=0, MD_Result=0, MD_Done=0 immediately; no later done pulse.
- MUL 0xFFFFFFFF*2, then MULHU same operands -> results 0xFFFFFFFE and 0x00000001. Each shows MD_Done on cycle 33 after start and MD_Stall high for cycles 0..32.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Special cases, each with done 1 cycle after start:
  - DIV x/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- Flush: assert EX_Flush at CALC cycle 5 of DIV -> IDLE next cycle, no done pulse, MD_Result keeps its previous value. A back-to-back MUL after DONE starts only on the next IDLE cycle.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide, one bit per cycle. Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module ex_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     EX_Instr,
    input  logic [XLEN-1:0] EX_RD1,
    input  logic [XLEN-1:0] EX_RD2,
    input  logic            EX_MulDiv_Valid,
    input  logic            EX_Flush,
    output logic            MD_Stall,
    output logic            MD_Busy,
    output logic            MD_Done,
    output logic [XLEN-1:0] MD_Result
);
    localparam int CW = $clog2(ITER);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_f3;
    logic                r_neg_a;
    logic                r_neg_b;
    logic [XLEN-1:0]     r_b;
    logic [2*XLEN-1:0]   r_acc;
    logic                r_done;
    logic [XLEN-1:0]     r_result;

    logic [2:0]          w_f3;
    logic                w_is_div_in;
    logic                w_sa_in;
    logic                w_sb_in;
    logic                w_neg_a_in;
    logic                w_neg_b_in;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic                w_start;
    logic                w_div0;
    logic                w_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_special_res;
    logic [XLEN:0]       w_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_rem_sh;
    logic [XLEN:0]       w_diff;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_step;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fix_res;
    logic                w_unused;

    assign w_f3        = EX_Instr[14:12];
    assign w_is_div_in = w_f3[2];
    // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM
    assign w_sa_in     = (w_f3 == 3'b001) | (w_f3 == 3'b010) | (w_f3 == 3'b100) | (w_f3 == 3'b110);
    assign w_sb_in     = (w_f3 == 3'b001) | (w_f3 == 3'b100) | (w_f3 == 3'b110);
    assign w_neg_a_in  = w_sa_in & EX_RD1[XLEN-1];
    assign w_neg_b_in  = w_sb_in & EX_RD2[XLEN-1];
    assign w_abs_a     = w_neg_a_in ? -EX_RD1 : EX_RD1;
    assign w_abs_b     = w_neg_b_in ? -EX_RD2 : EX_RD2;
    assign w_unused    = ^{EX_Instr[31:15], EX_Instr[11:0]};

    assign w_start     = (r_state == S_IDLE) & EX_MulDiv_Valid & ~EX_Flush;
    assign w_div0      = w_is_div_in & (EX_RD2 == '0);
    assign w_ovf       = w_is_div_in & ~w_f3[0] & (EX_RD1 == MIN_NEG) & (&EX_RD2);
    assign w_special   = w_div0 | w_ovf;
    assign w_special_res = w_div0 ? (w_f3[1] ? EX_RD1 : '1)
                                  : (w_f3[1] ? '0 : MIN_NEG);

    // Multiply: acc = {partial_hi, multiplier}; add multiplicand and shift right
    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract
    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff     = w_rem_sh - {1'b0, r_b};
    assign w_div_next = w_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                     : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    assign w_step     = r_f3[2] ? w_div_next : w_mul_next;
    assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_mul_next : w_mul_next;
    assign w_quo      = (r_neg_a ^ r_neg_b) ? -w_div_next[XLEN-1:0] : w_div_next[XLEN-1:0];
    assign w_rem      = r_neg_a ? -w_div_next[2*XLEN-1:XLEN] : w_div_next[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
        case (r_f3)
            3'b000:         w_fix_res = w_prod_fix[XLEN-1:0];
            3'b100, 3'b101: w_fix_res = w_quo;
            3'b110, 3'b111: w_fix_res = w_rem;
            default:        w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    // Product modulo 2^(2*XLEN) is exact for every signedness mix
    logic [2*XLEN-1:0] w_fa;
    logic [2*XLEN-1:0] w_fb;
    logic [2*XLEN-1:0] w_fast_prod;
    logic [XLEN-1:0]   w_fast_res;
    assign w_fa        = {{XLEN{w_neg_a_in}}, EX_RD1};
    assign w_fb        = {{XLEN{w_neg_b_in}}, EX_RD2};
    assign w_fast_prod = w_fa * w_fb;
    assign w_fast_res  = (w_f3 == 3'b000) ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (EX_Flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (EX_MulDiv_Valid) begin
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!w_is_div_in) begin
                            r_result <= w_fast_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
`endif
                        else begin
                            r_f3    <= w_f3;
                            r_neg_a <= w_neg_a_in;
                            r_neg_b <= w_neg_b_in;
                            r_b     <= w_abs_b;
                            r_acc   <= {{XLEN{1'b0}}, w_abs_a};
                            r_cnt   <= '0;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(ITER-1)) begin
                        r_result <= w_fix_res;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign MD_Stall  = w_start | (r_state == S_CALC);
    assign MD_Busy   = (r_state != S_IDLE);
    assign MD_Done   = r_done;
    assign MD_Result = r_result;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed RV32M cases plus randomized ops against an
// arithmetic reference and a cycle-level latency model.
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic [31:0] rd1 = '0;
    logic [31:0] rd2 = '0;
    logic        valid = 1'b0;
    logic        flush = 1'b0;
    logic        MD_Stall, MD_Busy, MD_Done;
    logic [31:0] MD_Result;

`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = 33;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk(clk), .rst(rst), .EX_Instr(instr), .EX_RD1(rd1), .EX_RD2(rd2),
        .EX_MulDiv_Valid(valid), .EX_Flush(flush),
        .MD_Stall(MD_Stall), .MD_Busy(MD_Busy), .MD_Done(MD_Done), .MD_Result(MD_Result)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int lat_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
        if (!f3[2]) return LAT_MUL;
        return 33;
    endfunction

    // Latency model: cycles left until the done cycle, done flag, visible result
    int          m_left;
    logic        m_done;
    logic [31:0] m_res, m_pend;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0; m_done <= 1'b0; m_res <= '0; m_pend <= '0;
        end else if (flush) begin
            m_left <= 0; m_done <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin m_done <= 1'b1; m_res <= m_pend; end
        end else if (valid) begin
            if (lat_md(instr[14:12], rd1, rd2) == 1) begin
                m_done <= 1'b1; m_res <= ref_md(instr[14:12], rd1, rd2);
            end else begin
                m_pend <= ref_md(instr[14:12], rd1, rd2);
                m_left <= lat_md(instr[14:12], rd1, rd2) - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic e_busy, e_stall;
            e_busy  = (m_left > 0) || m_done;
            e_stall = (m_left > 0) || (!e_busy && valid && !flush);
            chk("stall", {31'b0, MD_Stall}, {31'b0, e_stall});
            chk("busy",  {31'b0, MD_Busy},  {31'b0, e_busy});
            chk("done",  {31'b0, MD_Done},  {31'b0, m_done});
            chk("result", MD_Result, m_res);
        end
    end

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int explat);
        int cyc;
        bit got;
        @(posedge clk); #1;
        instr = mk_instr(f3); rd1 = a; rd2 = b; valid = 1'b1;
        cyc = 0; got = 0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            if (MD_Done) got = 1;
            else begin @(posedge clk); #1; cyc++; end
        end
        chk($sformatf("lat f3=%0d", f3), 32'(cyc), 32'(explat));
        chk($sformatf("res f3=%0d %h/%h", f3, a, b), MD_Result, exp);
        #1 valid = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit seen;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", {31'b0, MD_Busy}, 32'd0);
        chk("rst done", {31'b0, MD_Done}, 32'd0);
        chk("rst result", MD_Result, 32'd0);
        chk("rst stall", {31'b0, MD_Stall}, 32'd0);
        rst = 1'b0;

        do_op(3'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, LAT_MUL);
        do_op(3'd3, 32'hFFFFFFFF, 32'd2, 32'h00000001, LAT_MUL);
        do_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, LAT_MUL);
        do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_MUL);
        do_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        do_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        do_op(3'd5, 32'd100, 32'd7, 32'd14, 33);
        do_op(3'd7, 32'd100, 32'd7, 32'd2, 33);
        do_op(3'd4, 32'd12345, 32'd0, 32'hFFFFFFFF, 1);
        do_op(3'd7, 32'd5, 32'd0, 32'd5, 1);
        do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

        // Flush a DIV mid-calculation: no done, result keeps 0x80000000
        @(posedge clk); #1;
        instr = mk_instr(3'd4); rd1 = 32'd50; rd2 = 32'd3; valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 flush = 1'b1; valid = 1'b0;
        @(posedge clk); #1 flush = 1'b0;
        chk("flush busy", {31'b0, MD_Busy}, 32'd0);
        seen = 0;
        repeat (40) begin @(negedge clk); if (MD_Done) seen = 1; end
        chk("flush no done", {31'b0, seen}, 32'd0);
        chk("flush result", MD_Result, 32'h80000000);

        // Start request presented during DONE is taken on the following IDLE cycle
        do_op(3'd5, 32'd100, 32'd7, 32'd14, 33);
        instr = mk_instr(3'd0); rd1 = 32'd3; rd2 = 32'd5; valid = 1'b1;
        cyc = 0; seen = 0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1; cyc++;
            @(negedge clk); if (MD_Done) seen = 1;
        end
        #1 valid = 1'b0;
        chk("b2b lat", 32'(cyc), 32'(1 + LAT_MUL));
        chk("b2b res", MD_Result, 32'd15);

        // Reset in the middle of a DIVU
        @(posedge clk); #1;
        instr = mk_instr(3'd5); rd1 = 32'd100; rd2 = 32'd7; valid = 1'b1;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1; valid = 1'b0;
        #1;
        chk("rstmid busy", {31'b0, MD_Busy}, 32'd0);
        chk("rstmid result", MD_Result, 32'd0);
        chk("rstmid done", {31'b0, MD_Done}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        seen = 0;
        repeat (40) begin @(negedge clk); if (MD_Done) seen = 1; end
        chk("rstmid no done", {31'b0, seen}, 32'd0);

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            do_op(f3, a, b, ref_md(f3, a, b), lat_md(f3, a, b));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
